// File: rtl/instr_fetch_pkg.sv
// Shared fetch-stage types and instruction constants for the 9-bit CPU front end.
package instr_pack;

    typedef enum logic [1:0] {
        F_IDLE,
        F_RUN,
        F_HALT
    } fetch_state;

    localparam logic [4:0] OP_FUNC = 5'b11111;
    localparam logic [3:0] FN_DONE = 4'b1111;
    localparam logic [8:0] INSTR_DONE = {OP_FUNC, FN_DONE};

    function automatic logic is_done(input logic [8:0] word);
        return word == INSTR_DONE;
    endfunction

endpackage

// File: rtl/instr_fetch_fifo.sv
// Synchronous FIFO holding {pc, instr} words between ROM and decoder.
// Push and pop may coincide at any occupancy; flush empties it in one cycle.
module inst_fifo #(
    parameter int unsigned W     = 19,
    parameter int unsigned DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         push,
    input  logic                         pop,
    input  logic [W-1:0]                 din,
    output logic [W-1:0]                 dout,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         empty
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count_q;
    logic          do_push, do_pop;

    // A pop frees a slot for a same-cycle push, so a full FIFO can still accept.
    assign do_pop  = pop && (count_q != '0);
    assign do_push = push && ((count_q != CW'(DEPTH)) || do_pop);

    assign dout  = mem[rd_ptr];
    assign count = count_q;
    assign empty = (count_q == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem     <= '{default: '0};
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else if (flush) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: owns the PC, reads the 1-cycle ROM and feeds {pc, instr}
// to the decoder through a credit-limited FIFO; stops on the func-done word.
module instr_fetch
    import instr_pack::*;
#(
    parameter int unsigned PC_W     = 10,
    parameter int unsigned IW       = 9,
    parameter int unsigned DEPTH    = 2,
    parameter int unsigned START_PC = 0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic [IW-1:0]   imem_rdata,
    output logic            inst_valid,
    output logic [IW-1:0]   inst_data,
    output logic [PC_W-1:0] inst_pc,
    input  logic            inst_ready,
    input  logic            redirect_en,
    input  logic [PC_W-1:0] redirect_pc,
    output logic            halted
);
    localparam int unsigned     CW       = $clog2(DEPTH + 1);
    localparam logic [PC_W-1:0] PC_RESET = PC_W'(START_PC);
    localparam logic [CW:0]     CREDIT   = (CW+1)'(DEPTH);

    fetch_state state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d, addr_q;
    logic            stop_q, stop_d, inflight_q;

    logic               fifo_push, fifo_pop, fifo_flush, fifo_empty;
    logic [CW-1:0]      fifo_count;
    logic [PC_W+IW-1:0] fifo_head;
    logic [CW:0]        occupancy;

    inst_fifo #(
        .W     (PC_W + IW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (fifo_flush),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   ({addr_q, imem_rdata}),
        .dout  (fifo_head),
        .count (fifo_count),
        .empty (fifo_empty)
    );

    // Slots already claimed: entries left after this cycle's pop plus the response now arriving.
    assign occupancy = {1'b0, fifo_count} - {{CW{1'b0}}, fifo_pop} + {{CW{1'b0}}, inflight_q};

    assign inst_pc   = fifo_head[PC_W+IW-1:IW];
    assign inst_data = fifo_head[IW-1:0];
    assign halted    = (state_q == F_HALT);

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        stop_d     = stop_q;
        imem_req   = 1'b0;
        imem_addr  = pc_q;
        inst_valid = 1'b0;
        fifo_push  = 1'b0;
        fifo_pop   = 1'b0;
        fifo_flush = 1'b0;

        case (state_q)
            F_IDLE, F_HALT: begin
                if (start) begin
                    state_d    = F_RUN;
                    fifo_flush = 1'b1;
                    stop_d     = 1'b0;
                    imem_req   = 1'b1;
                    imem_addr  = PC_RESET;
                    pc_d       = PC_RESET + PC_W'(1);
                end
            end
            F_RUN: begin
                inst_valid = !fifo_empty;
                fifo_pop   = inst_valid && inst_ready;
                if (redirect_en) begin
                    // The response arriving now belongs to the old path: not pushed, FIFO cleared.
                    fifo_flush = 1'b1;
                    pc_d       = redirect_pc;
                    stop_d     = 1'b0;
                end else begin
                    fifo_push = inflight_q;
                    if (fifo_push && is_done(imem_rdata)) begin
                        stop_d = 1'b1;
                    end
                    if (fifo_pop && is_done(inst_data)) begin
                        state_d    = F_HALT;
                        fifo_flush = 1'b1;
                    end
                    if (!stop_d && (occupancy < CREDIT)) begin
                        imem_req = 1'b1;
                        pc_d     = pc_q + PC_W'(1);
                    end
                end
            end
            default: state_d = F_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= F_IDLE;
            pc_q       <= PC_RESET;
            stop_q     <= 1'b0;
            inflight_q <= 1'b0;
            addr_q     <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            stop_q     <= stop_d;
            inflight_q <= imem_req;
            if (imem_req) begin
                addr_q <= imem_addr;
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: directed programs with hand-computed {pc, instr} streams.
module tb_instr_fetch;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       imem_req;
    logic [9:0] imem_addr;
    logic [8:0] imem_rdata = '0;
    logic       inst_valid;
    logic [8:0] inst_data;
    logic [9:0] inst_pc;
    logic       inst_ready = 1'b0;
    logic       redirect_en = 1'b0;
    logic [9:0] redirect_pc = '0;
    logic       halted;

    logic [8:0]  rom [1024];
    logic [18:0] exp_q [$];
    logic [9:0]  req_addr [$];
    int          req_cyc [$];
    int          pop_cyc [$];
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          c0;
    int          hat;

    instr_fetch #(
        .PC_W     (10),
        .IW       (9),
        .DEPTH    (2),
        .START_PC (0)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .inst_valid  (inst_valid),
        .inst_data   (inst_data),
        .inst_pc     (inst_pc),
        .inst_ready  (inst_ready),
        .redirect_en (redirect_en),
        .redirect_pc (redirect_pc),
        .halted      (halted)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (imem_req) imem_rdata <= rom[imem_addr];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic monitor();
        logic [18:0] e;
        forever begin
            @(negedge clk);
            if (imem_req) begin
                req_addr.push_back(imem_addr);
                req_cyc.push_back(cyc);
            end
            if (inst_valid && inst_ready) begin
                pop_cyc.push_back(cyc);
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL sb_unexpected: got pc=%0h data=%0h required no output", inst_pc, inst_data);
                end else begin
                    e = exp_q.pop_front();
                    if ({inst_pc, inst_data} !== e) begin
                        n_bad++;
                        $display("FAIL sb_item: got pc=%0h data=%0h required pc=%0h data=%0h",
                                 inst_pc, inst_data, e[18:9], e[8:0]);
                    end
                end
            end
        end
    endtask

    task automatic rom_default();
        for (int i = 0; i < 1024; i++) rom[i] = 9'(i & 255);
    endtask

    task automatic expect_item(input logic [9:0] pc, input logic [8:0] data);
        exp_q.push_back({pc, data});
    endtask

    task automatic clear_logs();
        req_addr.delete();
        req_cyc.delete();
        pop_cyc.delete();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        start = 1'b0;
        redirect_en = 1'b0;
        #1;
        check("rst_valid", inst_valid, 0);
        check("rst_req", imem_req, 0);
        check("rst_halted", halted, 0);
        check("rst_addr", imem_addr, 0);
        exp_q.delete();
        tick();
        tick();
        reset = 1'b0;
        tick();
        clear_logs();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        c0 = cyc;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_halt(input int max, output int at);
        at = -1;
        for (int i = 0; i < max; i++) begin
            if (halted) begin
                at = cyc;
                break;
            end
            tick();
        end
        check("halt_seen", halted, 1);
        check("sb_drained", exp_q.size(), 0);
    endtask

    initial begin
        fork
            monitor();
        join_none

        // 1: streaming at full rate, done at pc 4
        rom_default();
        rom[0] = 9'h0A1; rom[1] = 9'h0B2; rom[2] = 9'h0C3; rom[3] = 9'h0D4; rom[4] = 9'h1FF;
        do_reset();
        inst_ready = 1'b1;
        expect_item(10'h000, 9'h0A1);
        expect_item(10'h001, 9'h0B2);
        expect_item(10'h002, 9'h0C3);
        expect_item(10'h003, 9'h0D4);
        expect_item(10'h004, 9'h1FF);
        pulse_start();
        wait_halt(30, hat);
        check("t1_halt_cycle", hat, c0 + 7);
        check("t1_nreq", req_addr.size(), 5);
        for (int k = 0; k < 5 && k < req_addr.size(); k++) begin
            check("t1_req_addr", req_addr[k], k);
            check("t1_req_cyc", req_cyc[k], c0 + k);
        end
        for (int k = 0; k < 5 && k < pop_cyc.size(); k++) check("t1_pop_cyc", pop_cyc[k], c0 + 2 + k);
        check("t1_valid_in_halt", inst_valid, 0);

        // 2 + 4: backpressure, done at pc 3, restart from HALT
        rom_default();
        rom[3] = 9'h1FF;
        do_reset();
        inst_ready = 1'b0;
        expect_item(10'h000, 9'h000);
        expect_item(10'h001, 9'h001);
        expect_item(10'h002, 9'h002);
        expect_item(10'h003, 9'h1FF);
        pulse_start();
        repeat (4) tick();
        check("t2_stall_nreq", req_addr.size(), 2);
        if (req_addr.size() >= 2) begin
            check("t2_stall_addr0", req_addr[0], 0);
            check("t2_stall_addr1", req_addr[1], 1);
        end
        check("t2_hold_valid", inst_valid, 1);
        check("t2_hold_pc", inst_pc, 0);
        inst_ready = 1'b1;
        wait_halt(30, hat);
        check("t4_no_req_past_done", req_addr.size(), 4);
        check("t4_valid_in_halt", inst_valid, 0);
        clear_logs();
        expect_item(10'h000, 9'h000);
        expect_item(10'h001, 9'h001);
        expect_item(10'h002, 9'h002);
        expect_item(10'h003, 9'h1FF);
        pulse_start();
        check("t4_restart_halted", halted, 0);
        wait_halt(30, hat);
        if (req_addr.size() > 0) check("t4_restart_addr", req_addr[0], 0);
        check("t4_restart_nreq", req_addr.size(), 4);

        // 3: redirect kills the in-flight response and the buffered word
        rom_default();
        rom[10'h043] = 9'h1FF;
        do_reset();
        inst_ready = 1'b0;
        expect_item(10'h040, 9'h040);
        expect_item(10'h041, 9'h041);
        expect_item(10'h042, 9'h042);
        expect_item(10'h043, 9'h1FF);
        pulse_start();
        tick();
        redirect_en = 1'b1;
        redirect_pc = 10'h040;
        tick();
        redirect_en = 1'b0;
        check("t3_empty_after_redirect", inst_valid, 0);
        inst_ready = 1'b1;
        wait_halt(30, hat);
        if (req_addr.size() > 2) begin
            check("t3_first_new_addr", req_addr[2], 10'h040);
            check("t3_first_new_cyc", req_cyc[2], c0 + 3);
        end else check("t3_req_count", req_addr.size(), 3);

        // 5: done buffered but redirected away before it is taken
        rom_default();
        rom[9] = 9'h1FF;
        rom[10'h022] = 9'h1FF;
        do_reset();
        inst_ready = 1'b0;
        expect_item(10'h008, 9'h008);
        expect_item(10'h020, 9'h020);
        expect_item(10'h021, 9'h021);
        expect_item(10'h022, 9'h1FF);
        pulse_start();
        redirect_en = 1'b1;
        redirect_pc = 10'h008;
        tick();
        redirect_en = 1'b0;
        repeat (3) tick();
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        tick();
        check("t5_nreq_stopped", req_addr.size(), 3);
        check("t5_head_valid", inst_valid, 1);
        check("t5_head_pc", inst_pc, 10'h009);
        check("t5_head_data", inst_data, 9'h1FF);
        redirect_en = 1'b1;
        redirect_pc = 10'h020;
        tick();
        redirect_en = 1'b0;
        check("t5_no_halt", halted, 0);
        inst_ready = 1'b1;
        wait_halt(30, hat);
        if (req_addr.size() > 3) check("t5_resume_addr", req_addr[3], 10'h020);

        // 6: PC wrap 0x3FF -> 0x000, then reset while halted
        rom_default();
        rom[1] = 9'h1FF;
        do_reset();
        inst_ready = 1'b0;
        expect_item(10'h3FE, 9'h0FE);
        expect_item(10'h3FF, 9'h0FF);
        expect_item(10'h000, 9'h000);
        expect_item(10'h001, 9'h1FF);
        pulse_start();
        redirect_en = 1'b1;
        redirect_pc = 10'h3FE;
        tick();
        redirect_en = 1'b0;
        inst_ready = 1'b1;
        wait_halt(30, hat);
        check("t6_nreq", req_addr.size(), 5);
        if (req_addr.size() >= 5) begin
            check("t6_addr_3fe", req_addr[1], 10'h3FE);
            check("t6_addr_3ff", req_addr[2], 10'h3FF);
            check("t6_addr_wrap", req_addr[3], 10'h000);
        end
        #2;
        reset = 1'b1;
        #1;
        check("t6_async_halted", halted, 0);
        tick();
        reset = 1'b0;
        tick();

        // 7: asynchronous reset mid-stream drops everything in flight
        rom_default();
        do_reset();
        inst_ready = 1'b1;
        expect_item(10'h000, 9'h000);
        expect_item(10'h001, 9'h001);
        pulse_start();
        repeat (3) tick();
        check("t7_streaming", inst_valid, 1);
        reset = 1'b1;
        #1;
        check("t7_async_valid", inst_valid, 0);
        check("t7_async_req", imem_req, 0);
        check("t7_async_halted", halted, 0);
        check("t7_sb_drained", exp_q.size(), 0);
        tick();
        reset = 1'b0;
        repeat (4) tick();
        check("t7_idle_after_reset", inst_valid, 0);
        check("t7_no_req_after_reset", imem_req, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog");
    end

endmodule
